systolic_west_feeder: RTL

//  Upstream feeder for the int8 systolic array's west edge. Buffers activation

---
 rtl/systolic_west_feeder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/systolic_west_feeder.sv
// West-edge feeder for the int8 systolic array: buffers activation vectors in a
// FIFO and emits them diagonally skewed so row r lags row 0 by r cycles.
module systolic_west_feeder #(
  parameter int ROWS  = 4,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ROWS*8-1:0] s_data,
  input  logic              s_last,
  input  logic              i_hold,
  output logic [ROWS*8-1:0] o_west,
  output logic [ROWS-1:0]   o_wvalid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  logic [ROWS*8:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            push, pop;
  logic [ROWS*8:0] head;
  logic [ROWS*8-1:0] feed_data;
  logic            feed_valid;

  assign s_ready = (count_q < (AW+1)'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = (state_q == STREAM) && !i_hold && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // A push this cycle already counts as pending work, so the first pop happens the cycle after it lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!i_hold) begin
      case (state_q)
        IDLE: begin
          if ((count_q != '0) || push) state_d = STREAM;
        end
        STREAM: begin
          if (pop && head[ROWS*8]) begin
            state_d = FLUSH;
            cnt_d   = CW'(ROWS - 1);
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) done_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_last, s_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign feed_valid = pop;
  assign feed_data  = pop ? head[ROWS*8-1:0] : '0;

  // Stage 0 is the common output register; lane r adds r further stages.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [8:0] st_q [0:r];
    logic [8:0] st_d [0:r];

    always_comb begin
      st_d[0] = {feed_valid, feed_data[8*r +: 8]};
      for (int k = 1; k <= r; k++) st_d[k] = st_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= r; k++) st_q[k] <= '0;
      end else if (!i_hold) begin
        for (int k = 0; k <= r; k++) st_q[k] <= st_d[k];
      end
    end

    assign o_west[8*r +: 8] = st_q[r][7:0];
    assign o_wvalid[r]      = st_q[r][8];
  end

  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
